ref_pattern_checker: RTL and testbench

Parametrised reference-pattern store for the receiver chain, holding N words of Q bits with reset-loaded contents. It provides a random-access read/write port and a sequential checker mode. In checker mode, a stream of demodulated words is compared in order against the stored pattern and the bit errors are counted. It sits after the demapper and feeds BER counts to the test/status logic.

---
 rtl/ref_pattern_checker.sv | 157 +++++++++++++++
 tb/tb_ref_pattern_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ref_pattern_checker.sv
// ref_pattern_checker
// Reference-pattern store for the receiver chain. It holds N words of Q bits,
// loaded from INIT on reset, and has two uses:
//   - a random-access write port and a registered read port, and
//   - a checker that compares demodulated words, in order, against the
//     stored pattern and accumulates the bit-error count for BER reporting.
//
// Ports:
//   clk                 clock
//   rst_n               synchronous reset, ACTIVE-HIGH (legacy name kept)
//   wr_en/addr/data     write port; addresses >= N are ignored
//   rd_en/addr          read request; addresses >= N read as zero
//   rd_data, rd_valid   registered read result, one-cycle valid pulse
//   start               begin (or restart) a check frame
//   chk_valid/data      received word stream
//   busy                frame in progress
//   done                one-cycle pulse in the cycle after the last beat
//   err_cnt             saturating bit-error count of the current/last frame
module ref_pattern_checker #(
  parameter int unsigned        LOG2N = 6,
  parameter int unsigned        Q     = 1,
  parameter int unsigned        N     = 48,
  parameter logic [N*Q-1:0]     INIT  = 48'hF73F53F26099,
  parameter int unsigned        ERRW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [LOG2N-1:0] wr_addr,
  input  logic [Q-1:0]     wr_data,
  input  logic             rd_en,
  input  logic [LOG2N-1:0] rd_addr,
  output logic [Q-1:0]     rd_data,
  output logic             rd_valid,
  input  logic             start,
  input  logic             chk_valid,
  input  logic [Q-1:0]     chk_data,
  output logic             busy,
  output logic             done,
  output logic [ERRW-1:0]  err_cnt
);

  // Address range limit, one bit wider than the address so N = 2^LOG2N works.
  localparam logic [LOG2N:0]   N_W  = (LOG2N+1)'(N);
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N-1);
  // Sum width: counter plus room for one word's worth of errors.
  localparam int unsigned      SUMW = ERRW + $clog2(Q+1) + 1;
  localparam logic [SUMW-1:0]  ERR_MAX = SUMW'({ERRW{1'b1}});

  typedef enum logic {IDLE, RUN} state_t;

  logic [Q-1:0]     mem [N];

  state_t           state_q, state_d;
  logic [LOG2N-1:0] ptr_q, ptr_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [Q-1:0]     diff;
  logic [SUMW-1:0]  pc;
  logic [SUMW-1:0]  sum;
  logic [ERRW-1:0]  err_sat;

  // Storage and read port. Reads sample mem before this edge's write lands,
  // which gives old-data behaviour on a same-address read/write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem[i] <= INIT[i*Q +: Q];
      end
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_en && ({1'b0, wr_addr} < N_W)) begin
        mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
        rd_data  <= ({1'b0, rd_addr} < N_W) ? mem[rd_addr] : '0;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

  // Bit errors of the current beat against the entry the frame has reached.
  always_comb begin
    diff = chk_data ^ mem[ptr_q];
    pc   = '0;
    for (int unsigned b = 0; b < Q; b++) begin
      pc = pc + SUMW'(diff[b]);
    end
    sum     = SUMW'(err_q) + pc;
    err_sat = (sum > ERR_MAX) ? '1 : ERRW'(sum);
  end

  // Checker state register.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      err_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Checker next state. start outranks chk_valid, so a beat arriving with a
  // restart is dropped.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = '0;
          ptr_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (start) begin
          err_d  = '0;
          ptr_d  = '0;
          busy_d = 1'b1;
        end else if (chk_valid) begin
          err_d = err_sat;
          if (ptr_q == LAST) begin
            ptr_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err_cnt = err_q;

endmodule

// File: tb/tb_ref_pattern_checker.sv
module tb_ref_pattern_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en, start, chk_valid;
  logic [5:0]  wr_addr, rd_addr;
  logic [0:0]  wr_data, chk_data;

  logic [0:0]  rd_data, rd_data4;
  logic        rd_valid, rd_valid4, busy, busy4, done, done4;
  logic [15:0] err_cnt;
  logic [3:0]  err_cnt4;

  int checks = 0;
  int fails  = 0;
  logic [47:0] init_v;
  logic [47:0] img;

  always #5 clk = ~clk;

  ref_pattern_checker dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .start(start), .chk_valid(chk_valid), .chk_data(chk_data),
    .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  ref_pattern_checker #(.ERRW(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data4), .rd_valid(rd_valid4),
    .start(start), .chk_valid(chk_valid), .chk_data(chk_data),
    .busy(busy4), .done(done4), .err_cnt(err_cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input int addr, input logic [31:0] exp);
    rd_en   = 1'b1;
    rd_addr = 6'(addr);
    tick();
    rd_en = 1'b0;
    check(tag, {31'd0, rd_data}, exp);
  endtask

  // Beats first..last of the frame with random idle gaps; word i = INIT[i] ^ flip[i].
  task automatic beats(input logic [47:0] flip, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int ngap;
      ngap = int'($urandom_range(0, 2));
      for (int g = 0; g < ngap; g++) begin
        chk_valid = 1'b0;
        tick();
        check("gap_busy", {31'd0, busy}, 32'd1);
      end
      chk_valid = 1'b1;
      chk_data  = init_v[i] ^ flip[i];
      tick();
      chk_valid = 1'b0;
      if (i != 47) begin
        check("beat_busy", {31'd0, busy}, 32'd1);
        check("beat_nodone", {31'd0, done}, 32'd0);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_err0", {16'd0, err_cnt}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    init_v = 48'hF73F53F26099;
    rst_n = 1'b1; wr_en = 1'b0; rd_en = 1'b0; start = 1'b0; chk_valid = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; chk_data = '0;
    tick(); tick();
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_rd_data", {31'd0, rd_data}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {16'd0, err_cnt}, 32'd0);
    rst_n = 1'b0;

    // 1: back-to-back reads, one-cycle latency
    begin
      int addrs[5];
      logic exps[5];
      addrs = '{0, 1, 3, 2, 47};
      exps  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      rd_en = 1'b1;
      for (int k = 0; k < 5; k++) begin
        rd_addr = 6'(addrs[k]);
        tick();
        check("rd_valid_burst", {31'd0, rd_valid}, 32'd1);
        check("rd_data_burst", {31'd0, rd_data}, {31'd0, exps[k]});
      end
      rd_en = 1'b0;
      tick();
      check("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
      check("rd_data_hold", {31'd0, rd_data}, 32'd1);
    end

    // 2: writes, out-of-range write, same-cycle read/write, reset restore
    wr_en = 1'b1; wr_addr = 6'd1; wr_data = 1'b1;
    tick();
    wr_en = 1'b0;
    read_chk("wr_rd_addr1", 1, 32'd1);
    wr_en = 1'b1; wr_addr = 6'd50; wr_data = 1'b1;
    tick();
    wr_en = 1'b0;
    img = init_v;
    img[1] = 1'b1;
    for (int a = 0; a < 48; a++) read_chk("img_after_oob_wr", a, {31'd0, img[a]});
    read_chk("rd_oob_zero", 50, 32'd0);
    wr_en = 1'b1; wr_addr = 6'd3; wr_data = 1'b0;
    read_chk("rw_same_old", 3, 32'd1);
    wr_en = 1'b0;
    read_chk("rw_same_new", 3, 32'd0);
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    read_chk("rst_restore1", 1, 32'd0);
    read_chk("rst_restore3", 3, 32'd1);

    // 3: clean frame with gaps; done one cycle after beat 48
    tick();
    chk_valid = 1'b1;
    tick();
    chk_valid = 1'b0;
    check("idle_ignores_valid", {31'd0, busy}, 32'd0);
    pulse_start();
    beats(48'd0, 0, 47);
    check("f3_done", {31'd0, done}, 32'd1);
    check("f3_busy", {31'd0, busy}, 32'd0);
    check("f3_err", {16'd0, err_cnt}, 32'd0);
    tick();
    check("f3_done_1cyc", {31'd0, done}, 32'd0);

    // 4: words 0, 10, 47 inverted; restart in done cycle with clean frame
    pulse_start();
    beats((48'd1 << 0) | (48'd1 << 10) | (48'd1 << 47), 0, 47);
    check("f4_done", {31'd0, done}, 32'd1);
    check("f4_err", {16'd0, err_cnt}, 32'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", {31'd0, busy}, 32'd1);
    check("b2b_err0", {16'd0, err_cnt}, 32'd0);
    check("b2b_done0", {31'd0, done}, 32'd0);
    beats(48'd0, 0, 47);
    check("b2b_done", {31'd0, done}, 32'd1);
    check("b2b_err", {16'd0, err_cnt}, 32'd0);
    tick();
    check("err_held_after_done", {16'd0, err_cnt}, 32'd0);

    // 5: restart mid-frame with a colliding (erroneous) beat
    pulse_start();
    beats((48'd1 << 1) | (48'd1 << 4) | (48'd1 << 7) | (48'd1 << 12) | (48'd1 << 19), 0, 19);
    check("f5_err5", {16'd0, err_cnt}, 32'd5);
    start = 1'b1; chk_valid = 1'b1; chk_data = ~init_v[20];
    tick();
    start = 1'b0; chk_valid = 1'b0;
    check("restart_err0", {16'd0, err_cnt}, 32'd0);
    check("restart_busy", {31'd0, busy}, 32'd1);
    beats(48'd0, 0, 46);
    check("restart_not_done47", {31'd0, done}, 32'd0);
    check("restart_busy47", {31'd0, busy}, 32'd1);
    beats(48'd0, 47, 47);
    check("restart_done", {31'd0, done}, 32'd1);
    check("restart_err", {16'd0, err_cnt}, 32'd0);

    // 6: saturation in the ERRW=4 instance, then reset mid-frame
    tick();
    pulse_start();
    beats('1, 0, 47);
    check("sat_done4", {31'd0, done4}, 32'd1);
    check("sat_err4", {28'd0, err_cnt4}, 32'd15);
    check("nosat_err16", {16'd0, err_cnt}, 32'd48);
    tick();
    check("sat_held4", {28'd0, err_cnt4}, 32'd15);
    pulse_start();
    beats('1, 0, 29);
    check("midframe_err30", {16'd0, err_cnt}, 32'd30);
    rst_n = 1'b1;
    chk_valid = 1'b1; chk_data = 1'b0;
    tick();
    rst_n = 1'b0;
    chk_valid = 1'b0;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_err", {16'd0, err_cnt}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      chk_valid = 1'b1;
      tick();
      check("post_rst_no_done", {31'd0, done}, 32'd0);
      check("post_rst_err", {16'd0, err_cnt}, 32'd0);
    end
    chk_valid = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
